// File: rtl/sysid_regs_avmm_if.sv
// Avalon-MM slave bus bundle for the system-ID register block.
// One word-addressed port with fixed read latency of one clock.
interface sysid_regs_avmm_if #(
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [31:0]       writedata;
   logic [3:0]        byteenable;
   logic [31:0]       readdata;

   modport master (
      output address, read, write, writedata, byteenable,
      input  readdata
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output readdata
   );
endinterface

// File: rtl/sysid_regs_avmm.sv
// System-ID register slave: build ID, timestamp, uptime with
// coherent 64-bit snapshot, lockable scratch and user words.
module sysid_regs_avmm #(
   parameter logic [31:0] ID             = 32'h5313_5AC2,
   parameter logic [31:0] TIMESTAMP      = 32'h0,
   parameter int          ADDR_W         = 4,
   parameter int          NUM_USER_WORDS = 2,
   parameter logic [32*(NUM_USER_WORDS>0?NUM_USER_WORDS:1)-1:0]
                          USER_DATA      = '0,
   parameter int          TICK_DIV       = 1,
   parameter logic [31:0] SCRATCH_RESET  = 32'h0
) (
   input logic              clock,
   input logic              reset_n,
   sysid_regs_avmm_if.slave bus
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);
   localparam logic [7:0] NUM_U8 = 8'(NUM_USER_WORDS);

   localparam logic [ADDR_W-1:0] A_ID   = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_TS   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_LO   = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_HI   = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] A_SCR  = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(5);

   logic [PW-1:0] prescaler;
   logic [63:0]   counter;
   logic [31:0]   shadow;
   logic [31:0]   scratch;
   logic [31:0]   rdata;
   logic          lock;
   logic          tick;
   logic          ctrl_wr;
   logic          clr;
   logic          scr_wr;
   logic          lo_rd;

   assign tick    = (prescaler == PS_MAX);
   assign ctrl_wr = bus.write && (bus.address == A_CTRL) &&
                    bus.byteenable[0];
   assign clr     = ctrl_wr && bus.writedata[1];
   assign scr_wr  = bus.write && (bus.address == A_SCR) && !lock;
   assign lo_rd   = bus.read && (bus.address == A_LO);

   // CLR takes priority over a coincident tick.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         prescaler <= '0;
         counter   <= '0;
      end else if (clr) begin
         prescaler <= '0;
         counter   <= '0;
      end else if (tick) begin
         prescaler <= '0;
         counter   <= counter + 64'd1;
      end else begin
         prescaler <= prescaler + PW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lock <= 1'b0;
      end else if (ctrl_wr && bus.writedata[0]) begin
         lock <= 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         scratch <= SCRATCH_RESET;
      end else if (scr_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.byteenable[i]) begin
               scratch[8*i +: 8] <= bus.writedata[8*i +: 8];
            end
         end
      end
   end

   always_comb begin
      rdata = '0;
      case (bus.address)
         A_ID:    rdata = ID;
         A_TS:    rdata = TIMESTAMP;
         A_LO:    rdata = counter[31:0];
         A_HI:    rdata = shadow;
         A_SCR:   rdata = scratch;
         A_CTRL:  rdata = {16'h0, NUM_U8, 7'h0, lock};
         default: begin
            for (int k = 0; k < NUM_USER_WORDS; k++) begin
               if (bus.address == ADDR_W'(6 + k)) begin
                  rdata = USER_DATA[32*k +: 32];
               end
            end
         end
      endcase
   end

   // Shadow captures the high word in the same edge as the LO read.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus.readdata <= '0;
         shadow       <= '0;
      end else begin
         if (bus.read) begin
            bus.readdata <= rdata;
         end
         if (lo_rd) begin
            shadow <= counter[63:32];
         end
      end
   end
endmodule
